fetch_queue: RTL and testbench

Instruction prefetch queue sitting directly upstream of the decode stage. It owns the program counter, drives the instruction ROM address, and buffers fetched instructions with their PCs in a small FIFO. Decode pulls them through a valid/ready handshake and can redirect fetch on a taken branch. This lets fetch run ahead while decode stalls on a RAW hazard, so a hazard no longer freezes the PC.

---
 rtl/fetch_queue.sv | 110 +++++++++++
 tb/tb_fetch_queue.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the PC, fetches from a combinational ROM and buffers {inst, pc} pairs for decode.
// Optional same-cycle empty-queue bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [11:0] rom_addr,
  input  logic [15:0] rom_data,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  input  logic        inst_ready
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [15:0]      pc_reg, pc_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W:0]   count_reg, count_next;

  logic [15:0] inst_mem [DEPTH];
  logic [15:0] pc_mem   [DEPTH];

  logic queue_empty;
  logic push;
  logic pop;
  logic bypass_take;
  logic write_en;
  logic pop_queue;

  assign queue_empty = (count_reg == '0);
  // Push decision looks only at registered count, so a full queue never refills in the cycle it pops.
  assign push        = (count_reg != FULL_COUNT) && !redirect_valid;
  assign rom_addr    = pc_reg[11:0];

  always_comb begin
    inst_valid = !queue_empty;
    inst       = queue_empty ? 16'h0000 : inst_mem[rd_ptr_reg];
    inst_pc    = queue_empty ? 16'h0000 : pc_mem[rd_ptr_reg];
`ifdef FETCH_QUEUE_BYPASS_EN
    if (queue_empty && push) begin
      inst_valid = 1'b1;
      inst       = rom_data;
      inst_pc    = pc_reg;
    end
`endif
  end

  assign pop = inst_valid && inst_ready && !redirect_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
  // A bypassed word taken by decode is never written into storage.
  assign bypass_take = queue_empty && push && inst_ready;
`else
  assign bypass_take = 1'b0;
`endif

  assign write_en  = push && !bypass_take;
  assign pop_queue = pop && !queue_empty;

  always_comb begin
    pc_next     = pc_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (redirect_valid) begin
      pc_next     = redirect_pc;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push)      pc_next     = pc_reg + 16'd2;
      if (write_en)  wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop_queue) rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({write_en, pop_queue})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_reg     <= 16'h0000;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      pc_reg     <= pc_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage carries no reset so it maps onto plain distributed RAM.
  always_ff @(posedge clock) begin
    if (write_en) begin
      inst_mem[wr_ptr_reg] <= rom_data;
      pc_mem[wr_ptr_reg]   <= pc_reg;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a combinational ROM model: word at address a is 16'h1000 + a.
module tb_fetch_queue;

  logic        clock;
  logic        reset;
  logic [11:0] rom_addr;
  logic [15:0] rom_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_ready;

  int tests_run;
  int tests_failed;

  fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready)
  );

  assign rom_data = 16'h1000 + {4'h0, rom_addr};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
    $display("[TB] %s observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [15:0] exp_pc, input logic [11:0] exp_addr);
    check({tag, ".valid"}, {15'd0, inst_valid}, 16'h0001);
    check({tag, ".inst_pc"}, inst_pc, exp_pc);
    check({tag, ".inst"}, inst, 16'h1000 + {4'h0, exp_pc[11:0]});
    check({tag, ".rom_addr"}, {4'h0, rom_addr}, {4'h0, exp_addr});
  endtask

  task automatic check_empty(input string tag, input logic [11:0] exp_addr);
    check({tag, ".valid"}, {15'd0, inst_valid}, 16'h0000);
    check({tag, ".inst"}, inst, 16'h0000);
    check({tag, ".inst_pc"}, inst_pc, 16'h0000);
    check({tag, ".rom_addr"}, {4'h0, rom_addr}, {4'h0, exp_addr});
  endtask

  // Called at posedge+1; reset pulses low for 1 time unit between edges.
  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    inst_ready     = 1'b0;

    // Reset state
    #12;
    check_empty("reset", 12'h000);

    // Streaming with ready held high: one instruction per cycle
    inst_ready = 1'b1;
    reset      = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_head($sformatf("stream%0d", k), 16'(2 * (k - 1)), 12'(2 * k));
    end

    // Stall until full: pc stops at 8, head stays at pc 0
    inst_ready = 1'b0;
    pulse_reset();
    for (int k = 0; k < 10; k++) tick();
    check_head("full", 16'h0000, 12'h008);

    // Pop while full: no push that cycle
    inst_ready = 1'b1;
    tick();
    check_head("full_pop", 16'h0002, 12'h008);
    inst_ready = 1'b0;
    tick();
    check_head("refill", 16'h0002, 12'h00A);
    tick();
    check_head("full_hold", 16'h0002, 12'h00A);

    // Drain continues past the stall point
    inst_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      check_head($sformatf("drain%0d", j), 16'(4 + 2 * j), (j == 0) ? 12'h00A : 12'(10 + 2 * j));
    end

    // Redirect with 3 entries queued and ready high: queued entries discarded
    inst_ready = 1'b0;
    pulse_reset();
    for (int k = 0; k < 3; k++) tick();
    check_head("pre_redirect", 16'h0000, 12'h006);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    check_empty("redirect", 12'h040);
    tick();
    check_head("redirect_first", 16'h0040, 12'h042);
    tick();
    check_head("redirect_second", 16'h0042, 12'h044);

    // Redirect to the top of the address space: pc wraps to 0
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    tick();
    redirect_valid = 1'b0;
    check_empty("wrap_redirect", 12'hFFE);
    tick();
    check_head("wrap_fffe", 16'hFFFE, 12'h000);
    tick();
    check_head("wrap_0000", 16'h0000, 12'h002);

    // Asynchronous reset between edges with the queue full
    inst_ready = 1'b0;
    pulse_reset();
    for (int k = 0; k < 5; k++) tick();
    check_head("async_full", 16'h0000, 12'h008);
    #2;
    reset = 1'b0;
    #1;
    check_empty("async_reset", 12'h000);
    reset = 1'b1;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    check_head("release_bypass", 16'h0000, 12'h000);
`else
    check_empty("release", 12'h000);
`endif
    tick();
    check_head("release_first", 16'h0000, 12'h002);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
